// File: rtl/ureg_pkg.sv
// Shared definitions for the universal parallel register.
// Mode codes and the mode type are used by the top level, the next-value logic
// and anything that drives the register.
package ureg_pkg;

    typedef logic [2:0] ureg_mode_t;

    localparam ureg_mode_t MODE_HOLD = 3'b000;
    localparam ureg_mode_t MODE_LOAD = 3'b001;
    localparam ureg_mode_t MODE_SHL  = 3'b010;
    localparam ureg_mode_t MODE_SHR  = 3'b011;
    localparam ureg_mode_t MODE_ROL  = 3'b100;
    localparam ureg_mode_t MODE_ROR  = 3'b101;
    localparam ureg_mode_t MODE_INC  = 3'b110;
    localparam ureg_mode_t MODE_DEC  = 3'b111;

endpackage

// File: rtl/ureg_next_value.sv
// Combinational next-state logic of the universal parallel register.
// Maps the current word and carry, the mode and the data inputs onto the value
// the register takes when the operation is enabled.
// Build option: define UREG_COUNT_EN to build the INC/DEC adder; without it the
// two counting modes behave as HOLD.
module ureg_next_value
    import ureg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur_out,
    input  logic             cur_carry,
    input  ureg_mode_t       mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic             serial_in,
    output logic [WIDTH-1:0] next_out,
    output logic             next_carry
);

    // Select the operation result; unlisted modes leave word and carry alone.
    always_comb begin
        next_out   = cur_out;
        next_carry = cur_carry;
        case (mode)
            MODE_LOAD: begin
                next_out   = load_val;
                next_carry = 1'b0;
            end
            MODE_SHL: begin
                next_out   = {cur_out[WIDTH-2:0], serial_in};
                next_carry = cur_out[WIDTH-1];
            end
            MODE_SHR: begin
                next_out   = {serial_in, cur_out[WIDTH-1:1]};
                next_carry = cur_out[0];
            end
            MODE_ROL: begin
                next_out   = {cur_out[WIDTH-2:0], cur_out[WIDTH-1]};
                next_carry = cur_out[WIDTH-1];
            end
            MODE_ROR: begin
                next_out   = {cur_out[0], cur_out[WIDTH-1:1]};
                next_carry = cur_out[0];
            end
`ifdef UREG_COUNT_EN
            // One bit wider than the word so the top bit is carry-out or borrow.
            MODE_INC: begin
                {next_carry, next_out} = {1'b0, cur_out} + (WIDTH+1)'(1);
            end
            MODE_DEC: begin
                {next_carry, next_out} = {1'b0, cur_out} - (WIDTH+1)'(1);
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/universal_parallel_register.sv
// Universal parallel register: hold, load, shift, rotate and (optionally)
// count a WIDTH-bit word, with a registered carry flag and a zero flag.
// Build option: define UREG_COUNT_EN to enable the INC/DEC modes.
module universal_parallel_register
    import ureg_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             preset,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] in,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] op_out;
    logic             op_carry;

    ureg_next_value #(
        .WIDTH (WIDTH)
    ) u_next (
        .cur_out    (out_q),
        .cur_carry  (carry_q),
        .mode       (ureg_mode_t'(mode)),
        .load_val   (in),
        .serial_in  (serial_in),
        .next_out   (op_out),
        .next_carry (op_carry)
    );

    // Preset beats the enabled operation; otherwise the register holds.
    always_comb begin
        out_d   = out_q;
        carry_d = carry_q;
        if (preset) begin
            out_d   = PRESET_VALUE;
            carry_d = 1'b0;
        end else if (enable) begin
            out_d   = op_out;
            carry_d = op_carry;
        end
    end

    // State register; clear overrides everything else at the edge.
    always_ff @(posedge clk) begin
        if (clear) begin
            out_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign out   = out_q;
    assign carry = carry_q;
    assign zero  = (out_q == '0);

endmodule

// File: tb/tb_universal_parallel_register.sv
// Self-checking bench for universal_parallel_register (WIDTH=8, PRESET=FF).
// Directed scenarios with fixed expectations, then randomized cycles checked
// against an arithmetic reference model. Adapts to the UREG_COUNT_EN build.
module tb_universal_parallel_register;
    import ureg_pkg::*;

`ifdef UREG_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       preset = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [7:0] in = 8'h00;
    logic       serial_in = 1'b0;
    logic [7:0] out;
    logic       carry;
    logic       zero;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: word as a plain integer 0..255 and the flag.
    int m_out   = 0;
    int m_carry = 0;

    universal_parallel_register #(
        .WIDTH        (8),
        .PRESET_VALUE (8'hFF)
    ) dut (
        .clk       (clk),
        .clear     (clear),
        .preset    (preset),
        .enable    (enable),
        .mode      (mode),
        .in        (in),
        .serial_in (serial_in),
        .out       (out),
        .carry     (carry),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare DUT against the reference model.
    task automatic chk_model(input string tag);
        chk({tag, ".out"},   {1'b0, out},   9'(m_out));
        chk({tag, ".carry"}, {8'h00, carry}, 9'(m_carry));
        chk({tag, ".zero"},  {8'h00, zero},  9'(m_out == 0));
    endtask

    // Compare DUT against fixed values from the scenario description.
    task automatic chk_exp(input string tag, input logic [7:0] e_out, input logic e_carry);
        chk({tag, ".out"},   {1'b0, out},    {1'b0, e_out});
        chk({tag, ".carry"}, {8'h00, carry}, {8'h00, e_carry});
        chk({tag, ".zero"},  {8'h00, zero},  {8'h00, (e_out == 8'h00)});
    endtask

    // Reference behaviour written with integer arithmetic.
    task automatic model(input bit c, input bit p, input bit e, input int md,
                         input int d, input int s);
        int o;
        o = m_out;
        if (c) begin
            m_out = 0; m_carry = 0;
        end else if (p) begin
            m_out = 255; m_carry = 0;
        end else if (e) begin
            case (md)
                1: begin m_out = d; m_carry = 0; end
                2: begin m_out = (o * 2) % 256 + s;   m_carry = o / 128; end
                3: begin m_out = o / 2 + s * 128;     m_carry = o % 2;   end
                4: begin m_out = (o * 2) % 256 + o / 128; m_carry = o / 128; end
                5: begin m_out = o / 2 + (o % 2) * 128;   m_carry = o % 2;   end
                6: if (COUNT_EN) begin m_out = (o + 1) % 256; m_carry = (o == 255) ? 1 : 0; end
                7: if (COUNT_EN) begin m_out = (o + 255) % 256; m_carry = (o == 0) ? 1 : 0; end
                default: ;
            endcase
        end
    endtask

    // Drive one command, clock it in, advance the model, sample 1ns after the edge.
    task automatic step(input bit c, input bit p, input bit e, input logic [2:0] md,
                        input logic [7:0] d, input bit s);
        clear = c; preset = p; enable = e; mode = md; in = d; serial_in = s;
        @(posedge clk);
        model(c, p, e, int'(md), int'(d), int'(s));
        #1;
    endtask

    initial begin
        #2;
        // Reset / priority
        step(1, 1, 1, MODE_LOAD, 8'h55, 0);
        chk_exp("reset_both", 8'h00, 1'b0);
        step(0, 1, 1, MODE_LOAD, 8'h55, 0);
        chk_exp("preset", 8'hFF, 1'b0);

        // Load / enable
        step(0, 0, 0, MODE_LOAD, 8'hA5, 0);
        chk_exp("load_dis", 8'hFF, 1'b0);
        step(0, 0, 1, MODE_LOAD, 8'hA5, 0);
        chk_exp("load_en", 8'hA5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, MODE_LOAD, 8'h3C, 0);
            chk_exp("hold_dis", 8'hA5, 1'b0);
        end

        // Shift
        step(0, 0, 1, MODE_LOAD, 8'h81, 0);
        step(0, 0, 1, MODE_SHL, 8'h00, 0);
        chk_exp("shl", 8'h02, 1'b1);
        step(0, 0, 1, MODE_SHR, 8'h00, 1);
        chk_exp("shr", 8'h81, 1'b0);

        // Rotate
        step(0, 0, 1, MODE_ROL, 8'h00, 0);
        chk_exp("rol", 8'h03, 1'b1);
        step(0, 0, 1, MODE_LOAD, 8'h81, 0);
        step(0, 0, 1, MODE_ROR, 8'h00, 0);
        chk_exp("ror1", 8'hC0, 1'b1);
        step(0, 0, 1, MODE_ROR, 8'h00, 0);
        chk_exp("ror2", 8'h60, 1'b0);

        // Count
        step(0, 0, 1, MODE_LOAD, 8'hFE, 0);
        step(0, 0, 1, MODE_INC, 8'h00, 0);
        chk_exp("inc1", COUNT_EN ? 8'hFF : 8'hFE, 1'b0);
        step(0, 0, 1, MODE_INC, 8'h00, 0);
        chk_exp("inc2", COUNT_EN ? 8'h00 : 8'hFE, COUNT_EN);
        step(0, 0, 1, MODE_DEC, 8'h00, 0);
        chk_exp("dec_wrap", COUNT_EN ? 8'hFF : 8'hFE, COUNT_EN);

        // Mid-operation clear
        step(1, 0, 0, MODE_HOLD, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, MODE_INC, 8'h00, 0);
        chk_exp("inc5", COUNT_EN ? 8'h05 : 8'h00, 1'b0);
        step(1, 0, 1, MODE_INC, 8'h00, 0);
        chk_exp("mid_clear", 8'h00, 1'b0);
        step(0, 0, 1, MODE_INC, 8'h00, 0);
        chk_exp("resume", COUNT_EN ? 8'h01 : 8'h00, 1'b0);
        chk_model("directed_end");

        // Randomized cycles against the reference model
        for (int i = 0; i < 400; i++) begin
            bit c, p, e, s;
            logic [2:0] md;
            logic [7:0] d;
            c  = ($urandom_range(0, 31) == 0);
            p  = ($urandom_range(0, 23) == 0);
            e  = ($urandom_range(0, 4) != 0);
            md = 3'($urandom_range(0, 7));
            d  = 8'($urandom_range(0, 255));
            s  = 1'($urandom_range(0, 1));
            step(c, p, e, md, d, s);
            chk_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
